multicycle_sequencer: RTL
=========================

# multicycle_sequencer

Multi-cycle control FSM that sequences the single-cycle fetch/decode/execute/memory/writeback datapath over several clocks. It handshakes with instruction and data memories, latches the decoder's control outputs, and gates the architectural-state write enables into single-cycle pulses. It also provides run/halt control and a retired-instruction counter. It sits between the decoder and the register file, PC register and memory ports.

## Interface
- COUNT_BITS, 32, width of retired-instruction counter
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- halt  in  1  halt request, sampled only at end of WB
- imem_ready  in  1  instruction memory has valid data (may be high in the same cycle as imem_req)
- dmem_ready  in  1  data memory access complete (may be high in the same cycle as dmem_req)
- dec_wEn  in  1  decoder register-write enable
- dec_mem_wEn  in  1  decoder store enable
- dec_wb_sel  in  1  decoder load select (1 = load)
- dec_next_PC_select  in  1  redirect request, valid during EXECUTE
- imem_req  out  1  fetch request
- ir_load  out  1  instruction register capture strobe
- dmem_req  out  1  data memory request
- mem_wEn  out  1  gated store enable
- load_capture  out  1  load-data register capture strobe
- reg_wEn  out  1  gated register-file write enable
- pc_wEn  out  1  PC update strobe
- pc_sel  out  1  0 = PC+4, 1 = target_PC
- halted  out  1  core is in HALT
- state  out  3  current state, for debug
- instret  out  COUNT_BITS  retired-instruction count

## Operation
- State encoding:
  - BOOT = 0, FETCH = 1, DECODE = 2, EXECUTE = 3, MEM = 4, WB = 5, HALT = 6.
  - Code 7 goes to BOOT on the next clock.
- BOOT: all strobes 0. Goes to FETCH unconditionally.
- FETCH:
  - imem_req = 1.
  - If imem_ready = 1: ir_load = 1 in that same cycle, then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE:
  - Latch wen_q = dec_wEn, st_q = dec_mem_wEn and ld_q = dec_wb_sel.
  - Go to EXECUTE.
- EXECUTE:
  - Latch sel_q = dec_next_PC_select.
  - If st_q or ld_q is set, go to MEM; otherwise go to WB.
  - If st_q and ld_q are both set, treat the instruction as a store (ld_q ignored).
- MEM:
  - dmem_req = 1 and mem_wEn = st_q, both held until dmem_ready.
  - When dmem_ready = 1: load_capture = ld_q & ~st_q in that cycle, then go to WB.
- WB:
  - reg_wEn = wen_q, pc_wEn = 1, pc_sel = sel_q, each for exactly one cycle.
  - instret increments by 1 at the end of WB, wrapping from all-ones to 0.
  - If halt = 1, go to HALT; otherwise go to FETCH.
- HALT:
  - halted = 1, all strobes 0.
  - If halt = 0, go to FETCH.
- All outputs are Moore outputs decoded from state and latched bits, except ir_load and load_capture, which also depend on the ready inputs.
- pc_sel is 0 in every state except WB.

## Timing
- While reset is low:
  - State is BOOT.
  - All outputs are 0, including instret and the latched bits.
  - Assertion of reset takes effect immediately (asynchronous), including mid-MEM with a store pending. The store is abandoned and mem_wEn drops without waiting for a clock.
- First imem_req is asserted 1 cycle after reset deasserts (BOOT to FETCH).
- Latency with zero-wait memories:
  - ALU, branch and jump instructions: 4 cycles (FETCH, DECODE, EXECUTE, WB).
  - Load and store instructions: 5 cycles.
  - Each wait cycle on imem or dmem adds exactly 1 cycle.
- Handshakes:
  - A request is held high until its ready input is seen.
  - A ready input is ignored in any state other than the one that asserted the corresponding request.
- reg_wEn, pc_wEn and instret change only in WB; no write enable fires twice per instruction.
- halt asserted in any state other than WB has no effect until the current instruction retires.

## Test plan
- Reset, zero-wait imem, ADD (dec_wEn = 1): state sequence 0, 1, 2, 3, 5, 1; reg_wEn and pc_wEn high only in cycle 5 with pc_sel = 0; instret = 1.
- Load with dmem_ready delayed 3 cycles: dmem_req high for 4 cycles; load_capture high only in the 4th of those cycles; mem_wEn = 0 throughout; WB follows with reg_wEn = 1; total latency 8 cycles.
- Store, then taken branch (dec_next_PC_select = 1 in EXECUTE): store has mem_wEn = 1 during MEM and reg_wEn = 0 in WB; branch has pc_sel = 1 in its WB; instret = 2.
- halt = 1 raised during DECODE: the instruction retires, state goes to 6 and halted = 1; halt = 0 resumes with imem_req = 1 the following cycle.
- reset pulled low mid-MEM with a store pending and dmem_ready = 0: mem_wEn and dmem_req drop to 0 immediately; instret = 0; restart goes through BOOT then FETCH.
- Preload instret to all-ones via forced value, retire one instruction: instret = 0.

Source files
------------

// File: rtl/multicycle_sequencer_if.sv
// Bundle of control/handshake signals between the multicycle sequencer
// and the decoder, memories, register file and PC register around it.
//
// Handshake rules (imem and dmem alike): the sequencer raises a request
// and holds it until the matching ready is seen high at a rising clock.
// Ready may already be high in the same cycle as the request. A ready is
// ignored in every state except the one that raised its request.
interface multicycle_sequencer_if #(
  parameter int COUNT_BITS = 32
) ();
  logic                  halt;
  logic                  imem_ready;
  logic                  dmem_ready;
  logic                  dec_wEn;
  logic                  dec_mem_wEn;
  logic                  dec_wb_sel;
  logic                  dec_next_PC_select;
  logic                  imem_req;
  logic                  ir_load;
  logic                  dmem_req;
  logic                  mem_wEn;
  logic                  load_capture;
  logic                  reg_wEn;
  logic                  pc_wEn;
  logic                  pc_sel;
  logic                  halted;
  logic [2:0]            state;
  logic [COUNT_BITS-1:0] instret;

  // Sequencer side
  modport master (
    input  halt, imem_ready, dmem_ready, dec_wEn, dec_mem_wEn, dec_wb_sel,
           dec_next_PC_select,
    output imem_req, ir_load, dmem_req, mem_wEn, load_capture, reg_wEn,
           pc_wEn, pc_sel, halted, state, instret
  );

  // Datapath / memory / environment side
  modport slave (
    output halt, imem_ready, dmem_ready, dec_wEn, dec_mem_wEn, dec_wb_sel,
           dec_next_PC_select,
    input  imem_req, ir_load, dmem_req, mem_wEn, load_capture, reg_wEn,
           pc_wEn, pc_sel, halted, state, instret
  );
endinterface

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM: steps the datapath through
// FETCH/DECODE/EXECUTE/MEM/WB, latches decoder controls, gates the
// architectural write enables into one-cycle pulses, and provides
// run/halt control plus a retired-instruction counter.
module multicycle_sequencer #(
  parameter int COUNT_BITS = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  multicycle_sequencer_if.master  bus
);

  typedef enum logic [2:0] {
    S_BOOT    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXECUTE = 3'd3,
    S_MEM     = 3'd4,
    S_WB      = 3'd5,
    S_HALT    = 3'd6
  } state_e;

  state_e                state_q, state_d;
  logic                  wen_q, st_q, ld_q, sel_q;
  logic [COUNT_BITS-1:0] instret_q;

  logic imem_req_d, ir_load_d, dmem_req_d, mem_wen_d, load_capture_d;
  logic reg_wen_d, pc_wen_d, pc_sel_d, halted_d;

  // State register; reset forces BOOT immediately, dropping any pending request
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and strobe decode; only ir_load/load_capture look at ready inputs
  always_comb begin
    state_d        = state_q;
    imem_req_d     = 1'b0;
    ir_load_d      = 1'b0;
    dmem_req_d     = 1'b0;
    mem_wen_d      = 1'b0;
    load_capture_d = 1'b0;
    reg_wen_d      = 1'b0;
    pc_wen_d       = 1'b0;
    pc_sel_d       = 1'b0;
    halted_d       = 1'b0;
    case (state_q)
      S_BOOT: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        imem_req_d = 1'b1;
        if (bus.imem_ready) begin
          ir_load_d = 1'b1;
          state_d   = S_DECODE;
        end
      end
      S_DECODE: begin
        state_d = S_EXECUTE;
      end
      S_EXECUTE: begin
        state_d = (st_q || ld_q) ? S_MEM : S_WB;
      end
      S_MEM: begin
        dmem_req_d = 1'b1;
        mem_wen_d  = st_q;
        if (bus.dmem_ready) begin
          // A combined store+load is treated as a store: no load capture
          load_capture_d = ld_q & ~st_q;
          state_d        = S_WB;
        end
      end
      S_WB: begin
        reg_wen_d = wen_q;
        pc_wen_d  = 1'b1;
        pc_sel_d  = sel_q;
        state_d   = bus.halt ? S_HALT : S_FETCH;
      end
      S_HALT: begin
        halted_d = 1'b1;
        if (!bus.halt) begin
          state_d = S_FETCH;
        end
      end
      default: begin
        // Unused code 7 recovers through BOOT
        state_d = S_BOOT;
      end
    endcase
  end

  // Latch decoder controls in DECODE/EXECUTE and count retirements in WB
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wen_q     <= 1'b0;
      st_q      <= 1'b0;
      ld_q      <= 1'b0;
      sel_q     <= 1'b0;
      instret_q <= '0;
    end else begin
      if (state_q == S_DECODE) begin
        wen_q <= bus.dec_wEn;
        st_q  <= bus.dec_mem_wEn;
        ld_q  <= bus.dec_wb_sel;
      end
      if (state_q == S_EXECUTE) begin
        sel_q <= bus.dec_next_PC_select;
      end
      if (state_q == S_WB) begin
        instret_q <= instret_q + 1'b1;
      end
    end
  end

  assign bus.imem_req     = imem_req_d;
  assign bus.ir_load      = ir_load_d;
  assign bus.dmem_req     = dmem_req_d;
  assign bus.mem_wEn      = mem_wen_d;
  assign bus.load_capture = load_capture_d;
  assign bus.reg_wEn      = reg_wen_d;
  assign bus.pc_wEn       = pc_wen_d;
  assign bus.pc_sel       = pc_sel_d;
  assign bus.halted       = halted_d;
  assign bus.state        = state_q;
  assign bus.instret      = instret_q;

endmodule
